gray_counter_n: RTL and testbench

Parametrised N-bit Gray-code counter: the next generation of the 3-bit up-only `gray` counter, generalised to any width and extended with up/down counting, synchronous parallel load, wrap or saturate mode, and separate sticky overflow/underflow flags. It serves as a general counter and sequencer in P1-level designs wherever Gray output is needed, for example pointer sources and single-bit-change state encodings. Output changes only on clock edges and is driven from registers.

---
 rtl/gray_pkg.sv | 14 +
 rtl/gray_counter_n.sv | 56 +++++
 tb/tb_gray_counter_n.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and direction constants.
package gray_pkg;
  localparam bit DIR_UP = 1'b1;
  localparam bit DIR_DOWN = 1'b0;
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_counter_n.sv
// gray_counter_n: N-bit up/down Gray counter with load, wrap/saturate and sticky end flags.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] next_bin;
  logic next_ovf, next_udf, next_wrap, up, at_end;
  assign up = Dir == DIR_UP;
  assign at_end = up ? BinOut == MAX : BinOut == '0;
  always_comb begin
    next_bin = BinOut;
    next_ovf = Overflow;
    next_udf = Underflow;
    next_wrap = 1'b0;
    if (Load) begin
      next_bin = LoadVal;
      next_ovf = 1'b0;
      next_udf = 1'b0;
    end else if (En) begin
      next_ovf = Overflow | (at_end & up);
      next_udf = Underflow | (at_end & ~up);
      next_wrap = at_end & ~SATURATE;
      next_bin = (at_end && SATURATE) ? BinOut : (up ? BinOut + 1'b1 : BinOut - 1'b1);
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      BinOut <= '0;
      Output <= '0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
      Wrap <= 1'b0;
    end else begin
      BinOut <= next_bin;
      Output <= WIDTH'(bin2gray(16'(next_bin)));
      Overflow <= next_ovf;
      Underflow <= next_udf;
      Wrap <= next_wrap;
    end
  end
endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n: wrap and saturate instances checked against a count model plus directed literals.
module tb_gray_counter_n;
  import gray_pkg::*;
  logic Clk = 0, Reset = 0, En = 0, Dir = 0, Load = 0;
  logic [2:0] LoadVal = '0;
  logic [2:0] out0, bin0, out1, bin1;
  logic ovf0, udf0, wrp0, ovf1, udf1, wrp1;
  int errors = 0, checks = 0;
  int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int m_cnt [2], m_ovf [2], m_udf [2], m_wrp [2];
  bit valid = 0;

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u_wrap (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load), .LoadVal(LoadVal),
    .Output(out0), .BinOut(bin0), .Overflow(ovf0), .Underflow(udf0), .Wrap(wrp0));
  gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) u_sat (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load), .LoadVal(LoadVal),
    .Output(out1), .BinOut(bin1), .Overflow(ovf1), .Underflow(udf1), .Wrap(wrp1));

  always #5 Clk = ~Clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    for (int s = 0; s < 2; s++) begin
      if (Reset) begin
        m_cnt[s] = 0; m_ovf[s] = 0; m_udf[s] = 0; m_wrp[s] = 0;
      end else if (Load) begin
        m_cnt[s] = int'(LoadVal); m_ovf[s] = 0; m_udf[s] = 0; m_wrp[s] = 0;
      end else if (En) begin
        int n;
        n = Dir ? m_cnt[s] + 1 : m_cnt[s] - 1;
        m_wrp[s] = 0;
        if (n > 7 || n < 0) begin
          if (Dir) m_ovf[s] = 1; else m_udf[s] = 1;
          if (s == 0) begin m_cnt[s] = (n + 8) % 8; m_wrp[s] = 1; end
        end else m_cnt[s] = n;
      end else m_wrp[s] = 0;
    end
    if (Reset) valid = 1;
  end

  logic [2:0] prev0, prev1;
  bit have_prev = 0;
  always @(posedge Clk) begin
    bit ld, rs;
    ld = Load; rs = Reset;
    #1;
    if (valid) begin
      chk("wrap_out", int'(out0), gray_tab[m_cnt[0]]);
      chk("wrap_bin", int'(bin0), m_cnt[0]);
      chk("wrap_ovf", int'(ovf0), m_ovf[0]);
      chk("wrap_udf", int'(udf0), m_udf[0]);
      chk("wrap_wrap", int'(wrp0), m_wrp[0]);
      chk("sat_out", int'(out1), gray_tab[m_cnt[1]]);
      chk("sat_bin", int'(bin1), m_cnt[1]);
      chk("sat_ovf", int'(ovf1), m_ovf[1]);
      chk("sat_udf", int'(udf1), m_udf[1]);
      chk("sat_wrap", int'(wrp1), m_wrp[1]);
      chk("wrap_g2b", int'(gray2bin(16'(out0))), int'(bin0));
      chk("sat_g2b", int'(gray2bin(16'(out1))), int'(bin1));
      if (have_prev && !ld && !rs) begin
        chk("wrap_onebit", int'($countones(prev0 ^ out0) <= 1), 1);
        chk("sat_onebit", int'($countones(prev1 ^ out1) <= 1), 1);
      end
      prev0 = out0; prev1 = out1; have_prev = 1;
    end
  end

  task automatic cyc(bit r, bit e, bit d, bit l, logic [2:0] lv);
    Reset = r; En = e; Dir = d; Load = l; LoadVal = lv;
    @(posedge Clk);
    #2;
  endtask

  initial begin
    int seq [10] = '{0, 1, 3, 2, 6, 7, 5, 4, 0, 1};
    int wraps;
    #2;
    cyc(1, 0, 0, 0, 0);
    chk("reset_out", int'(out0), 0);
    chk("reset_flags", int'({ovf0, udf0, wrp0}), 0);
    wraps = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 1, DIR_UP, 0, 0);
      chk("up_seq", int'(out0), seq[k]);
      chk("up_ovf", int'(ovf0), k >= 8 ? 1 : 0);
      wraps += int'(wrp0);
    end
    chk("up_wrap_count", wraps, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, DIR_DOWN, 0, 0);
    chk("down_out", int'(out0), 3'b100);
    chk("down_udf", int'(udf0), 1);
    chk("down_ovf", int'(ovf0), 0);
    chk("down_wrap", int'(wrp0), 1);
    cyc(0, 0, 0, 0, 0);
    chk("down_wrap_drop", int'(wrp0), 0);
    cyc(0, 0, 0, 1, 3'd6);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, DIR_UP, 0, 0);
      chk("sat_seq", int'(bin1), 7);
      chk("sat_ovf_lit", int'(ovf1), k >= 1 ? 1 : 0);
      chk("sat_nowrap", int'(wrp1), 0);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, DIR_DOWN, 0, 0);
    cyc(0, 1, DIR_UP, 0, 0);
    cyc(0, 1, DIR_UP, 0, 0);
    cyc(0, 1, DIR_UP, 0, 0);
    chk("pre_load_bin", int'(bin0), 2);
    chk("pre_load_flags", int'({ovf0, udf0}), 3);
    cyc(0, 1, DIR_UP, 1, 3'd5);
    chk("load_bin", int'(bin0), 5);
    chk("load_out", int'(out0), 3'b111);
    chk("load_flags", int'({ovf0, udf0, wrp0}), 0);
    cyc(0, 1, DIR_UP, 1, 3'd7);
    chk("load_max_ovf", int'(ovf0), 0);
    cyc(0, 1, DIR_UP, 0, 0);
    chk("load_max_then_up", int'({bin0, ovf0, wrp0}), 5'b00011);
    cyc(0, 0, 0, 1, 3'd4);
    cyc(1, 1, DIR_UP, 1, 3'd6);
    chk("midreset_out", int'(out0), 0);
    chk("midreset_flags", int'({ovf0, udf0, wrp0, ovf1, udf1, wrp1}), 0);
    for (int i = 0; i < 1000; i++)
      cyc($urandom_range(63) == 0, 1'($urandom), 1'($urandom), $urandom_range(7) == 0, 3'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
